sub_bytes_seq: RTL
==================

// Module: sub_bytes_seq
// PURPOSE
//   Forward AES SubBytes engine for the encrypt datapath; the counterpart of the decrypt-side inverse S-box.
//   Accepts a 128-bit state over a valid/ready handshake and substitutes LANES 32-bit words per cycle
//   through internal forward S-box instances (FIPS-197 table, 256x8, hard-coded).
//   Returns the result over a valid/ready handshake. Trades latency for S-box area.
// PARAMETERS
//   LANES  1  32-bit words substituted per cycle; legal values 1, 2, 4 (others: elaboration error)
// PORTS
//   clk        in   1    clock; all state updates on rising edge
//   reset      in   1    synchronous, active-high reset
//   in_valid   in   1    in_data valid
//   in_ready   out  1    block can accept a state this cycle
//   in_data    in   128  input state; byte0 = [127:120] ... byte15 = [7:0]; word w = [127-32w -: 32]
//   out_valid  out  1    out_data holds a completed SubBytes result
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  substituted state, same byte ordering as in_data
//   busy       out  1    high while in BUSY or DONE
// BEHAVIOUR
//   Decided: one clock; reset is synchronous and active-high.
//   - Reset values: FSM=IDLE, word counter=0, out_valid=0, busy=0, out_data=128'h0.
//   - in_ready=1 only in IDLE and not in reset.
//   - N = 4/LANES substitution cycles.
//   - FSM states:
//     IDLE: in_ready=1. On in_valid, latch in_data into the working register, counter<=0, go to BUSY.
//     BUSY: each cycle, replace words [cnt*LANES .. cnt*LANES+LANES-1] with S(byte) per byte;
//       counter += 1. Words are processed in ascending order (word 0 first).
//       When the last group is written, go to DONE.
//     DONE: out_valid=1; out_data is stable and equals the working register.
//       On out_ready, go to IDLE; out_valid drops in the next cycle.
//   - Timing: input accepted at edge E. The result is complete at edge E+N; out_valid is high from
//     the cycle after E+N. For LANES=1, an accepting edge at cycle 0 gives out_valid in cycle 5.
//   - Throughput: one state per N+2 cycles when out_ready is held high. No overlap: in_ready stays
//     low in DONE even while out_ready=1.
//   - in_data is sampled only at the accepting edge; later changes are ignored.
//   - out_valid, once asserted, holds until the handshake completes. out_data must not change
//     while out_valid=1.
//   - While out_valid=0, out_data is the working register (partially substituted) and must be
//     ignored downstream.
//   - Counter width is 2 bits and never wraps: the exit to DONE happens at cnt=N-1.
//     For LANES=4 the counter stays 0.
//   - Reset at any point, including mid-BUSY or in DONE: next cycle is IDLE with all reset values.
//     The in-flight state is discarded and no out_valid pulse is produced.
//   - in_valid in BUSY or DONE is ignored (in_ready=0). There is no buffering.
//   - Pure byte-wise mapping: no carries and no cross-byte dependence.
// TESTING
//   1. S-box corners, LANES=1: in_data=128'h00000000_01010101_53535353_ffffffff
//      -> out_data=128'h63636363_7c7c7c7c_edededed_16161616; out_valid first high 5 cycles after accept.
//   2. FIPS-197 round-1 vector, LANES=1,2,4: in=193de3be_a0f4e22b_9ac68d2a_e9f84808
//      -> out=d42711ae_e0bf98f1_b8b45de5_1e415230. Latency 5/3/2 cycles to out_valid.
//   3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable,
//      in_ready=0, busy=1. Assert out_ready -> exactly one transfer, then IDLE and in_ready=1.
//   4. Input-change immunity: change in_data and pulse in_valid during BUSY -> result matches the
//      originally accepted state; second request not taken.
//   5. Reset mid-op: reset at 2nd BUSY cycle -> next cycle in_ready=1, busy=0, out_valid=0.
//      A following request 128'h0 yields all-63.
//   6. Back-to-back: 8 random states with out_ready=1, checked against a reference model
//      -> all match, in order, each N+2 cycles apart.

Source files
------------

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_seq
// Purpose  : Sequential AES forward SubBytes. LANES 32-bit words per cycle
//            through a shared bank of forward S-boxes, valid/ready in and out.
// Revision : 1.0  initial release
// ============================================================================
module sub_bytes_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2 or 4");
    end

    localparam int unsigned N_GROUPS = 4 / LANES;
    localparam logic [1:0]  LAST_CNT = 2'(N_GROUPS - 1);

    // FIPS-197 forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   w_widx;
    logic [6:0]   w_hi;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        w_widx  = '0;
        w_hi    = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Only the words of the current group pass through the S-box bank.
                for (int l = 0; l < LANES; l++) begin
                    w_widx = 2'(int'(cnt_q) * LANES + l);
                    for (int b = 0; b < 4; b++) begin
                        w_hi = 7'(127 - 32 * int'(w_widx) - 8 * b);
                        work_d[w_hi -: 8] = sbox(work_q[w_hi -: 8]);
                    end
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = work_q;

endmodule
`default_nettype wire
